// File: rtl/reboot_seq_pkg.sv
// Shared state encoding and image-select constants for the warm-boot request path.
package reboot_seq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DETACH = 2'd1;
  localparam logic [1:0] ST_FIRE   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DETACH = ST_DETACH,
    FIRE   = ST_FIRE,
    DONE   = ST_DONE
  } state_t;

  localparam logic [1:0] IMG_BOOT = 2'b01;
  localparam logic [1:0] IMG_USER = 2'b10;

endpackage

// File: rtl/prio_arb.sv
// Combinational one-hot grant to the lowest-index asserted request.
module prio_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reboot_sequencer.sv
// Arbitrates warm-boot requests, holds USB detached for 2^DELAY_TW cycles, then
// fires a single boot_now strobe with the latched image; all outputs are flops.
module reboot_sequencer
  import reboot_seq_pkg::*;
#(
  parameter int N_SRC    = 2,
  parameter int DELAY_TW = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SRC-1:0]     req_valid,
  input  logic [2*N_SRC-1:0]   req_image,
  output logic [N_SRC-1:0]     req_ready,
  input  logic                 abort,
  output logic                 usb_detach,
  output logic                 busy,
  output logic [1:0]           boot_sel,
  output logic                 boot_now
);

  state_t              state, state_nxt;
  logic [DELAY_TW:0]   cnt, cnt_nxt;
  logic [N_SRC-1:0]    gnt, take, ready_nxt;
  logic [1:0]          img_take, sel_nxt;

  prio_arb #(.N(N_SRC)) u_arb (
    .req (req_valid),
    .gnt (gnt)
  );

  // req_ready is one-hot, so at most one source can complete a transfer
  assign take = req_valid & req_ready;

  always_comb begin
    img_take = 2'b00;
    for (int i = 0; i < N_SRC; i++) begin
      if (take[i]) img_take = req_image[2*i +: 2];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = boot_sel;
    ready_nxt = '0;
    case (state)
      IDLE: begin
        if (|take) begin
          state_nxt = DETACH;
          cnt_nxt   = '0;
          sel_nxt   = img_take;
        end else begin
          ready_nxt = gnt;
        end
      end
      DETACH: begin
        cnt_nxt = cnt + 1'b1;
        // abort beats the terminal count when both land on the same cycle
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_nxt[DELAY_TW]) begin
          state_nxt = FIRE;
        end
      end
      FIRE:    state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= '0;
      usb_detach <= 1'b0;
      busy       <= 1'b0;
      boot_sel   <= 2'b00;
      boot_now   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= ready_nxt;
      usb_detach <= (state_nxt != IDLE);
      busy       <= (state_nxt != IDLE);
      boot_sel   <= sel_nxt;
      boot_now   <= (state_nxt == FIRE);
    end
  end

endmodule
